// File: rtl/dt_window_sequencer.sv
// dt_window_sequencer: forward/backward raster pass controller feeding the distance-transform datapath.
// Optional feature: define DT_FG_COUNT_EN to add the fg_count output (forward-pass write-back counter).
module dt_window_sequencer #(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
`ifdef DT_FG_COUNT_EN
    output logic [ADDR_W-1:0]  fg_count,
`endif
    output logic               res_rd,
    output logic               res_wr,
    output logic [ADDR_W-1:0]  res_addr,
    output logic [PIX_W-1:0]   res_do,
    input  logic [PIX_W-1:0]   res_di,
    output logic               win_valid,
    output logic               win_backward,
    output logic [PIX_W-1:0]   win_center,
    output logic [4*PIX_W-1:0] win_nb,
    input  logic               dt_valid,
    input  logic [PIX_W-1:0]   dt_result
);
    localparam int CW = ADDR_W / 2;
    localparam logic [CW-1:0] LO = CW'(1);
    localparam logic [CW-1:0] HI = CW'(IMG_W - 2);

    typedef enum logic [3:0] {IDLE, RD_CTR, CHK, NB0, NB1, NB2, NB3, CAP, WAIT, WRITE, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          row, col, adv_row, adv_col;
    logic                   adv_bwd, last, adv;
    logic [3:0][PIX_W-1:0]  nb;

    assign win_nb = nb;

    // Address of neighbour k: NW,N,NE,W on the forward pass, E,SW,S,SE on the backward pass.
    function automatic logic [ADDR_W-1:0] nb_addr(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                                  input logic b, input logic [1:0] k);
        logic [CW-1:0] nr, nc;
        nr = b ? (k == 2'd0 ? r : r + 1'b1) : (k == 2'd3 ? r : r - 1'b1);
        nc = b ? (k == 2'd1 ? c - 1'b1 : k == 2'd2 ? c : c + 1'b1)
               : (k == 2'd0 || k == 2'd3 ? c - 1'b1 : k == 2'd1 ? c : c + 1'b1);
        return {nr, nc};
    endfunction

    // Next scan position; the forward pass hands over to the backward pass at the last centre.
    always_comb begin
        adv_row = row;
        adv_col = col;
        adv_bwd = win_backward;
        last    = 1'b0;
        if (!win_backward) begin
            if (col != HI) adv_col = col + 1'b1;
            else if (row != HI) begin
                adv_col = LO;
                adv_row = row + 1'b1;
            end else adv_bwd = 1'b1;
        end else begin
            if (col != LO) adv_col = col - 1'b1;
            else if (row != LO) begin
                adv_col = HI;
                adv_row = row - 1'b1;
            end else last = 1'b1;
        end
        adv = (state == CHK && res_di == '0) || state == WRITE;
    end

    // Sequencer: state, scan position, window capture and registered RAM strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_rd       <= 1'b0;
            res_wr       <= 1'b0;
            res_addr     <= '0;
            res_do       <= '0;
            win_valid    <= 1'b0;
            win_backward <= 1'b0;
            win_center   <= '0;
            nb           <= '0;
        end else begin
            res_rd <= 1'b0;
            res_wr <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state        <= RD_CTR;
                    busy         <= 1'b1;
                    win_backward <= 1'b0;
                    row          <= LO;
                    col          <= LO;
                    res_rd       <= 1'b1;
                    res_addr     <= {LO, LO};
                end
                RD_CTR: state <= CHK;
                CHK: begin
                    win_center <= res_di;
                    if (res_di != '0) begin
                        state    <= NB0;
                        res_rd   <= 1'b1;
                        res_addr <= nb_addr(row, col, win_backward, 2'd0);
                    end
                end
                NB0: begin
                    state    <= NB1;
                    res_rd   <= 1'b1;
                    res_addr <= nb_addr(row, col, win_backward, 2'd1);
                end
                NB1: begin
                    nb[0]    <= res_di;
                    state    <= NB2;
                    res_rd   <= 1'b1;
                    res_addr <= nb_addr(row, col, win_backward, 2'd2);
                end
                NB2: begin
                    nb[1]    <= res_di;
                    state    <= NB3;
                    res_rd   <= 1'b1;
                    res_addr <= nb_addr(row, col, win_backward, 2'd3);
                end
                NB3: begin
                    nb[2] <= res_di;
                    state <= CAP;
                end
                CAP: begin
                    nb[3]     <= res_di;
                    state     <= WAIT;
                    win_valid <= 1'b1;
                end
                WAIT: if (dt_valid) begin
                    win_valid <= 1'b0;
                    state     <= WRITE;
                    res_wr    <= 1'b1;
                    res_addr  <= {row, col};
                    res_do    <= dt_result;
                end
                WRITE: ;
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (adv) begin
                if (last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    state        <= RD_CTR;
                    res_rd       <= 1'b1;
                    res_addr     <= {adv_row, adv_col};
                    row          <= adv_row;
                    col          <= adv_col;
                    win_backward <= adv_bwd;
                end
            end
        end
    end

`ifdef DT_FG_COUNT_EN
    // Forward-pass write-backs since the last accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fg_count <= '0;
        else if (state == IDLE && start) fg_count <= '0;
        else if (state == WRITE && !win_backward) fg_count <= fg_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dt_window_sequencer.sv
// tb_dt_window_sequencer: full-size timing/scenario runs plus randomized small-image runs against a pass model.
module tb_dt_window_sequencer;
    localparam int CN = 16;
    localparam int DRF [4] = '{-1, -1, -1, 0};
    localparam int DCF [4] = '{-1, 0, 1, -1};
    localparam int DRB [4] = '{0, 1, 1, 1};
    localparam int DCB [4] = '{1, -1, 0, 1};

    typedef struct { bit wr; int addr; int data; } ev_t;
    typedef struct { int ctr; logic [31:0] nb; bit bwd; } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dp(input logic [7:0] ctr, input logic [31:0] n);
        int m = 255;
        for (int k = 0; k < 4; k++) if (int'(n[8*k +: 8]) < m) m = int'(n[8*k +: 8]);
        m = (m == 255) ? 255 : m + 1;
        return (int'(ctr) < m) ? ctr : 8'(m);
    endfunction

    // ---------------- instance A: 128x128, all-zero RAM ----------------
    logic a_rst, a_start, a_busy, a_done, a_rd, a_wr, a_wv, a_wb;
    logic [13:0] a_addr;
    logic [7:0]  a_do, a_ctr;
    logic [31:0] a_nb;
`ifdef DT_FG_COUNT_EN
    logic [13:0] a_fg, b_fg;
    logic [7:0]  c_fg;
`endif
    dt_window_sequencer u_a (
        .clk(clk), .reset(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
`ifdef DT_FG_COUNT_EN
        .fg_count(a_fg),
`endif
        .res_rd(a_rd), .res_wr(a_wr), .res_addr(a_addr), .res_do(a_do), .res_di(8'd0),
        .win_valid(a_wv), .win_backward(a_wb), .win_center(a_ctr), .win_nb(a_nb),
        .dt_valid(1'b0), .dt_result(8'd0)
    );

    // ---------------- instance B: 128x128, single pixel ----------------
    logic b_rst, b_start, b_busy, b_done, b_rd, b_wr, b_wv, b_wb, b_dtv, b_load;
    logic [13:0] b_addr;
    logic [7:0]  b_do, b_ctr, b_di;
    logic [31:0] b_nb;
    logic [7:0]  ram_b [16384];
    dt_window_sequencer u_b (
        .clk(clk), .reset(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
`ifdef DT_FG_COUNT_EN
        .fg_count(b_fg),
`endif
        .res_rd(b_rd), .res_wr(b_wr), .res_addr(b_addr), .res_do(b_do), .res_di(b_di),
        .win_valid(b_wv), .win_backward(b_wb), .win_center(b_ctr), .win_nb(b_nb),
        .dt_valid(b_dtv), .dt_result(dp(b_ctr, b_nb))
    );
    always @(posedge clk) begin
        if (b_load) begin
            for (int i = 0; i < 16384; i++) ram_b[i] <= 8'd0;
            ram_b[647] <= 8'd1;
        end else begin
            if (b_wr) ram_b[b_addr] <= b_do;
            if (b_rd) b_di <= ram_b[b_addr];
        end
    end

    // ---------------- instance C: 16x16, random images ----------------
    logic c_rst, c_start, c_busy, c_done, c_rd, c_wr, c_wv, c_wb, c_dtv, c_load;
    logic [7:0]  c_addr, c_do, c_ctr, c_di;
    logic [31:0] c_nb;
    logic [7:0]  ram_c [CN*CN];
    int          img_c [CN*CN];
    int          exp_img [CN*CN];
    int          exp_fg;
    ev_t         ev_q [$];
    win_t        win_q [$];
    dt_window_sequencer #(.IMG_W(CN), .ADDR_W(8), .PIX_W(8)) u_c (
        .clk(clk), .reset(c_rst), .start(c_start), .busy(c_busy), .done(c_done),
`ifdef DT_FG_COUNT_EN
        .fg_count(c_fg),
`endif
        .res_rd(c_rd), .res_wr(c_wr), .res_addr(c_addr), .res_do(c_do), .res_di(c_di),
        .win_valid(c_wv), .win_backward(c_wb), .win_center(c_ctr), .win_nb(c_nb),
        .dt_valid(c_dtv), .dt_result(dp(c_ctr, c_nb))
    );
    always @(posedge clk) begin
        if (c_load) begin
            for (int i = 0; i < CN*CN; i++) ram_c[i] <= 8'(img_c[i]);
        end else begin
            if (c_wr) ram_c[c_addr] <= c_do;
            if (c_rd) c_di <= ram_c[c_addr];
        end
    end

    // Two raster passes over the interior: expected RAM accesses, windows and final image.
    task automatic c_model();
        int img [CN*CN];
        int r, c, ctr, a;
        logic [31:0] pk;
        logic [7:0] res;
        ev_q.delete();
        win_q.delete();
        exp_fg = 0;
        for (int i = 0; i < CN*CN; i++) img[i] = img_c[i];
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < (CN-2)*(CN-2); i++) begin
                r = p ? CN-2 - i/(CN-2) : 1 + i/(CN-2);
                c = p ? CN-2 - i%(CN-2) : 1 + i%(CN-2);
                ctr = r*CN + c;
                ev_q.push_back('{1'b0, ctr, 0});
                if (img[ctr] != 0) begin
                    for (int k = 0; k < 4; k++) begin
                        a = p ? (r + DRB[k])*CN + c + DCB[k] : (r + DRF[k])*CN + c + DCF[k];
                        ev_q.push_back('{1'b0, a, 0});
                        pk[8*k +: 8] = 8'(img[a]);
                    end
                    res = dp(8'(img[ctr]), pk);
                    win_q.push_back('{img[ctr], pk, p[0]});
                    ev_q.push_back('{1'b1, ctr, int'(res)});
                    img[ctr] = int'(res);
                    if (p == 0) exp_fg++;
                end
            end
        end
        for (int i = 0; i < CN*CN; i++) exp_img[i] = img[i];
    endtask

    task automatic run_a();
        int rd_n = 0, wr_n = 0, ov = 0, done_n = 0, done_at = -1;
        logic busy1 = 1'b0, busy_pre = 1'b0, busy_end = 1'b1;
        a_start = 1'b1;
        for (int n = 1; n <= 63510; n++) begin
            @(negedge clk);
            a_start = (n == 100);
            if (a_rd) rd_n++;
            if (a_wr) wr_n++;
            if (a_rd && a_wr) ov++;
            if (a_done) begin
                done_n++;
                done_at = n;
            end
            if (n == 1) busy1 = a_busy;
            if (n == 63505) busy_pre = a_busy;
            if (n == 63506) busy_end = a_busy;
        end
        check("a_centre_reads", rd_n, 31752);
        check("a_writes", wr_n, 0);
        check("a_rd_wr_overlap", ov, 0);
        check("a_done_count", done_n, 1);
        check("a_done_cycle", done_at, 63505);
        check("a_busy_cycle1", busy1, 1);
        check("a_busy_in_done", busy_pre, 1);
        check("a_busy_after_done", busy_end, 0);
`ifdef DT_FG_COUNT_EN
        check("a_fg_count", a_fg, 0);
`endif
    endtask

    task automatic run_b();
        int rds [$], wra [$], wrd [$], wrb [$], hits [$];
        int wv_n = 0, wv_last = 0, chg = 0, busact = 0, done_at = -1, wr_at = -1, wr_seen = 0, first = -1;
        int fwd_nb [4] = '{518, 519, 520, 646};
        int bwd_nb [4] = '{648, 774, 775, 776};
        logic [7:0] c0;
        logic [31:0] n0;
        bit got = 0;
        b_dtv = 1'b0;
        b_start = 1'b1;
        for (int n = 1; n <= 63540; n++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_rd) rds.push_back(int'(b_addr));
            if (b_wr) begin
                wra.push_back(int'(b_addr));
                wrd.push_back(int'(b_do));
                wrb.push_back(int'(b_wb));
                if (wr_at < 0) wr_at = n;
            end
            if (b_wv && !b_wb) begin
                if (wv_n == 0) begin
                    c0 = b_ctr;
                    n0 = b_nb;
                end else if (b_ctr !== c0 || b_nb !== n0) chg++;
                if (b_rd || b_wr) busact++;
                wv_n++;
                wv_last = n;
                if (wv_n == 11) b_dtv = 1'b1;
            end
            if (b_done) done_at = n;
        end
        check("b_total_reads", rds.size(), 31760);
        check("b_total_writes", wra.size(), 2);
        for (int i = 0; i < rds.size(); i++) if (rds[i] == 647) hits.push_back(i);
        check("b_centre647_reads", hits.size(), 2);
        for (int h = 0; h < hits.size() && h < 2; h++)
            for (int k = 0; k < 4; k++)
                if (hits[h] + 1 + k < rds.size())
                    check(h ? "b_bwd_nb_addr" : "b_fwd_nb_addr", rds[hits[h]+1+k], h ? bwd_nb[k] : fwd_nb[k]);
        for (int i = 0; i < wra.size() && i < 2; i++) begin
            check("b_write_addr", wra[i], 647);
            check("b_write_data", wrd[i], 1);
            check("b_write_backward", wrb[i], i);
        end
        check("b_fwd_wait_cycles", wv_n, 11);
        check("b_window_changes", chg, 0);
        check("b_bus_in_wait", busact, 0);
        check("b_win_center", c0, 1);
        check("b_win_nb", n0, 0);
        check("b_write_cycle", wr_at, wv_last + 1);
        check("b_done_cycle", done_at, 63529);
        // Abort in the middle of a forward WAIT and restart.
        b_dtv = 1'b0;
        b_start = 1'b1;
        for (int n = 1; n <= 3000 && !got; n++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_wr) wr_seen++;
            if (b_wv) got = 1;
        end
        check("b_wait_reached", got, 1);
        b_rst = 1'b0;
        #1;
        check("b_rst_ctl", {b_busy, b_done, b_rd, b_wr, b_wv, b_wb}, 0);
        check("b_rst_addr", b_addr, 0);
        check("b_rst_data", {b_do, b_ctr, b_nb}, 0);
`ifdef DT_FG_COUNT_EN
        check("b_rst_fg", b_fg, 0);
`endif
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        check("b_idle_after_rst", {b_busy, b_rd, b_wr}, 0);
        b_start = 1'b1;
        b_dtv = 1'b1;
        for (int n = 1; n <= 10 && first < 0; n++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_wr) wr_seen++;
            if (b_rd) first = int'(b_addr);
        end
        check("b_restart_addr", first, 129);
        check("b_no_partial_write", wr_seen, 0);
    endtask

    task automatic run_c(input int dens);
        ev_t e;
        win_t w;
        int bad = 0, ov = 0;
        bit fin = 0, prev = 0;
        for (int i = 0; i < CN*CN; i++) img_c[i] = ($urandom_range(0, 99) < dens) ? int'($urandom_range(1, 255)) : 0;
        c_load = 1'b1;
        @(negedge clk);
        c_load = 1'b0;
        c_model();
        c_start = 1'b1;
        for (int n = 1; n <= 10000 && !fin; n++) begin
            @(negedge clk);
            c_start = c_busy && !c_done && ($urandom_range(0, 40) == 0);
            c_dtv = ($urandom_range(0, 2) != 0);
            if (c_rd && c_wr) ov++;
            if (c_rd || c_wr) begin
                if (ev_q.size() == 0) check("c_extra_access", 1, 0);
                else begin
                    e = ev_q.pop_front();
                    check("c_access_kind", c_wr, e.wr);
                    check("c_access_addr", c_addr, e.addr);
                    if (c_wr) check("c_write_data", c_do, e.data);
                end
            end
            if (c_wv && !prev) begin
                if (win_q.size() == 0) check("c_extra_window", 1, 0);
                else begin
                    w = win_q.pop_front();
                    check("c_win_center", c_ctr, w.ctr);
                    check("c_win_nb", c_nb, w.nb);
                    check("c_win_backward", c_wb, w.bwd);
                end
            end
            prev = c_wv;
            if (n == 1) begin
                check("c_busy_after_start", c_busy, 1);
`ifdef DT_FG_COUNT_EN
                check("c_fg_cleared", c_fg, 0);
`endif
            end
            if (c_done) begin
                fin = 1;
`ifdef DT_FG_COUNT_EN
                check("c_fg_count", c_fg, exp_fg);
`endif
            end
        end
        c_start = 1'b0;
        check("c_done_seen", fin, 1);
        @(negedge clk);
        check("c_busy_cleared", {c_busy, c_done}, 0);
        check("c_events_left", ev_q.size(), 0);
        for (int i = 0; i < CN*CN; i++) if (int'(ram_c[i]) != exp_img[i]) bad++;
        check("c_final_image", bad, 0);
        check("c_rd_wr_overlap", ov, 0);
`ifdef DT_FG_COUNT_EN
        repeat (3) @(negedge clk);
        check("c_fg_hold", c_fg, exp_fg);
`endif
    endtask

    task automatic run_c_all();
        run_c(30);
        run_c(70);
        run_c(100);
    endtask

    initial begin
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        b_dtv = 1'b0; c_dtv = 1'b0; c_load = 1'b0;
        b_load = 1'b1;
        repeat (2) @(negedge clk);
        b_load = 1'b0;
        check("a_rst_ctl", {a_busy, a_done, a_rd, a_wr, a_wv, a_wb}, 0);
        check("a_rst_addr", a_addr, 0);
        check("a_rst_data", {a_do, a_ctr, a_nb}, 0);
        check("c_rst_ctl", {c_busy, c_done, c_rd, c_wr, c_wv, c_wb}, 0);
        check("c_rst_data", {c_addr, c_do, c_ctr, c_nb}, 0);
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        @(negedge clk);
        fork
            run_a();
            run_b();
            run_c_all();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
